// File: rtl/registered_alu_if.sv
// Operand/opcode request and registered result/flag bundle for the ALU.
// Strict one-cycle valid semantics: in_valid=1 on an edge samples A/B/op_code; out_valid=1 marks a new result.
interface registered_alu_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [3:0]       op_code;
  logic             out_valid;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             negative;
  logic             carry;
  logic             overflow;

  modport master (
    output in_valid, A, B, op_code,
    input  out_valid, result, zero, negative, carry, overflow
  );

  modport slave (
    input  in_valid, A, B, op_code,
    output out_valid, result, zero, negative, carry, overflow
  );
endinterface

// File: rtl/registered_alu.sv
// Integer ALU with one registered output stage: result and Z/N/C/V flags one clock after in_valid.
// No backpressure; a new operation can be accepted every cycle.
module registered_alu #(
  parameter int WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  registered_alu_if.slave   bus
);
  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_XOR  = 4'h4;
  localparam logic [3:0] OP_SHL  = 4'h5;
  localparam logic [3:0] OP_SHR  = 4'h6;
  localparam logic [3:0] OP_MUL  = 4'h7;
  localparam logic [3:0] OP_ASR  = 4'h8;
  localparam logic [3:0] OP_ROL  = 4'h9;
  localparam logic [3:0] OP_ROR  = 4'hA;
  localparam logic [3:0] OP_NOT  = 4'hB;
  localparam logic [3:0] OP_INC  = 4'hC;
  localparam logic [3:0] OP_DEC  = 4'hD;
  localparam logic [3:0] OP_CMP  = 4'hE;
  localparam logic [3:0] OP_PASB = 4'hF;
  localparam int         MSB     = WIDTH - 1;

  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic [WIDTH-1:0]   add_b;
  logic [WIDTH-1:0]   sub_b;
  logic [WIDTH:0]     sum_ext;
  logic [WIDTH:0]     dif_ext;
  logic [2*WIDTH-1:0] prod;
  logic               add_v;
  logic               sub_v;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_c;
  logic               alu_v;

  logic             valid_d, valid_q;
  logic [WIDTH-1:0] result_d, result_q;
  logic             zero_d, zero_q;
  logic             negative_d, negative_q;
  logic             carry_d, carry_q;
  logic             overflow_d, overflow_q;

  assign a = bus.A;
  assign b = bus.B;

  // INC/DEC reuse the ADD/SUB adders with the second operand forced to 1.
  always_comb begin
    add_b   = (bus.op_code == OP_INC) ? WIDTH'(1) : b;
    sub_b   = (bus.op_code == OP_DEC) ? WIDTH'(1) : b;
    sum_ext = {1'b0, a} + {1'b0, add_b};
    dif_ext = {1'b0, a} - {1'b0, sub_b};
    prod    = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
    add_v   = (a[MSB] == add_b[MSB]) && (sum_ext[MSB] != a[MSB]);
    sub_v   = (a[MSB] != sub_b[MSB]) && (dif_ext[MSB] != a[MSB]);
  end

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (bus.op_code)
      OP_ADD, OP_INC: begin
        alu_res = sum_ext[WIDTH-1:0];
        alu_c   = sum_ext[WIDTH];
        alu_v   = add_v;
      end
      OP_SUB, OP_DEC, OP_CMP: begin
        alu_res = dif_ext[WIDTH-1:0];
        alu_c   = dif_ext[WIDTH];
        alu_v   = sub_v;
      end
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_XOR:  alu_res = a ^ b;
      OP_SHL: begin
        alu_res = {a[WIDTH-2:0], 1'b0};
        alu_c   = a[MSB];
      end
      OP_SHR: begin
        alu_res = {1'b0, a[WIDTH-1:1]};
        alu_c   = a[0];
      end
      OP_MUL: begin
        alu_res = prod[WIDTH-1:0];
        alu_c   = |prod[2*WIDTH-1:WIDTH];
      end
      OP_ASR: begin
        alu_res = {a[MSB], a[WIDTH-1:1]};
        alu_c   = a[0];
      end
      OP_ROL: begin
        alu_res = {a[WIDTH-2:0], a[MSB]};
        alu_c   = a[MSB];
      end
      OP_ROR: begin
        alu_res = {a[0], a[WIDTH-1:1]};
        alu_c   = a[0];
      end
      OP_NOT:  alu_res = ~a;
      OP_PASB: alu_res = b;
      default: alu_res = '0;
    endcase
  end

  // Flags are derived from the value being registered; idle cycles hold everything but out_valid.
  always_comb begin
    valid_d    = 1'b0;
    result_d   = result_q;
    zero_d     = zero_q;
    negative_d = negative_q;
    carry_d    = carry_q;
    overflow_d = overflow_q;
    if (bus.in_valid) begin
      valid_d    = 1'b1;
      result_d   = alu_res;
      zero_d     = ~|alu_res;
      negative_d = alu_res[MSB];
      carry_d    = alu_c;
      overflow_d = alu_v;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q    <= 1'b0;
      result_q   <= '0;
      zero_q     <= 1'b0;
      negative_q <= 1'b0;
      carry_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      valid_q    <= valid_d;
      result_q   <= result_d;
      zero_q     <= zero_d;
      negative_q <= negative_d;
      carry_q    <= carry_d;
      overflow_q <= overflow_d;
    end
  end

  assign bus.out_valid = valid_q;
  assign bus.result    = result_q;
  assign bus.zero      = zero_q;
  assign bus.negative  = negative_q;
  assign bus.carry     = carry_q;
  assign bus.overflow  = overflow_q;
endmodule

// File: tb/tb_registered_alu.sv
// Self-checking bench for registered_alu (WIDTH=8): directed cases, reset, hold, and random ops vs an integer model.
module tb_registered_alu;
  localparam int W = 8;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  int   last_r;
  int   last_f;

  registered_alu_if #(.WIDTH(W)) bus ();

  registered_alu #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int flags_now();
    return {28'd0, bus.zero, bus.negative, bus.carry, bus.overflow};
  endfunction

  function automatic int sgn(input int u);
    return (u >= 128) ? u - 256 : u;
  endfunction

  function automatic bit ovf(input int s);
    return (s > 127) || (s < -128);
  endfunction

  // Integer reference: r is the 8-bit result, f packs {Z,N,C,V}.
  function automatic void model(input int op, input int ua, input int ub, output int r, output int f);
    int c, v, full;
    c = 0; v = 0; r = 0;
    case (op)
      0:  begin full = ua + ub; r = full % 256; c = int'(full > 255); v = int'(ovf(sgn(ua) + sgn(ub))); end
      1, 14: begin r = (ua - ub + 256) % 256; c = int'(ua < ub); v = int'(ovf(sgn(ua) - sgn(ub))); end
      2:  r = ua & ub;
      3:  r = ua | ub;
      4:  r = ua ^ ub;
      5:  begin r = (ua * 2) % 256; c = int'(ua >= 128); end
      6:  begin r = ua / 2; c = ua % 2; end
      7:  begin full = ua * ub; r = full % 256; c = int'(full >= 256); end
      8:  begin r = ua / 2 + ((ua >= 128) ? 128 : 0); c = ua % 2; end
      9:  begin r = (ua * 2) % 256 + ua / 128; c = ua / 128; end
      10: begin r = ua / 2 + (ua % 2) * 128; c = ua % 2; end
      11: r = 255 - ua;
      12: begin r = (ua + 1) % 256; c = int'(ua == 255); v = int'(sgn(ua) == 127); end
      13: begin r = (ua + 255) % 256; c = int'(ua == 0); v = int'(sgn(ua) == -128); end
      default: r = ub;
    endcase
    f = (int'(r == 0) << 3) | (int'(r >= 128) << 2) | (c << 1) | v;
  endfunction

  task automatic drive(input int op, input int ua, input int ub);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.op_code  = 4'(op);
    bus.A        = 8'(ua);
    bus.B        = 8'(ub);
    @(posedge clk);
    #1;
  endtask

  // Directed step: expectations written out as constants, flags as {Z,N,C,V}.
  task automatic directed(input string tag, input int op, input int ua, input int ub,
                          input int exp_r, input int exp_f);
    drive(op, ua, ub);
    chk({tag, "_valid"}, int'(bus.out_valid), 1);
    chk({tag, "_result"}, int'(bus.result), exp_r);
    chk({tag, "_flags"}, flags_now(), exp_f);
    last_r = exp_r;
    last_f = exp_f;
  endtask

  task automatic idle_check(input string tag);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.A        = 8'($urandom_range(255));
    bus.B        = 8'($urandom_range(255));
    bus.op_code  = 4'($urandom_range(15));
    @(posedge clk);
    #1;
    chk({tag, "_valid"}, int'(bus.out_valid), 0);
    chk({tag, "_hold_result"}, int'(bus.result), last_r);
    chk({tag, "_hold_flags"}, flags_now(), last_f);
  endtask

  initial begin
    int op, ua, ub, er, ef;
    total = 0; bad = 0; last_r = 0; last_f = 0;
    bus.in_valid = 1'b0; bus.A = '0; bus.B = '0; bus.op_code = '0;
    rst_n = 1'b1;

    // Asynchronous reset with no edge: load something first, then pull reset mid-cycle.
    #2 rst_n = 1'b0;
    #1;
    chk("por_valid", int'(bus.out_valid), 0);
    chk("por_result", int'(bus.result), 0);
    chk("por_flags", flags_now(), 0);
    @(negedge clk) rst_n = 1'b1;
    directed("pre_reset_xor", 4, 8'hF0, 8'h0F, 8'hFF, 4'b0100);
    @(negedge clk);
    bus.in_valid = 1'b1; bus.op_code = 4'h0; bus.A = 8'd7; bus.B = 8'd9;
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", int'(bus.out_valid), 0);
    chk("async_rst_result", int'(bus.result), 0);
    chk("async_rst_flags", flags_now(), 0);
    bus.in_valid = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_idle_valid", int'(bus.out_valid), 0);
    chk("post_rst_idle_result", int'(bus.result), 0);
    last_r = 0; last_f = 0;

    // Directed cases, issued back-to-back on consecutive cycles.
    directed("add_ovf",  0, 100,   55,    155,   4'b0101);
    directed("sub_brw",  1, 30,    100,   186,   4'b0110);
    directed("add_wrap", 0, 255,   1,     0,     4'b1010);
    directed("and",      2, 8'hAA, 8'hCC, 8'h88, 4'b0100);
    directed("or",       3, 8'hA0, 8'h0F, 8'hAF, 4'b0100);
    directed("xor",      4, 8'hF0, 8'h0F, 8'hFF, 4'b0100);
    directed("shl",      5, 8'h81, 8'h00, 8'h02, 4'b0010);
    directed("shr",      6, 8'h03, 8'h00, 8'h01, 4'b0010);
    directed("asr",      8, 8'h80, 8'h00, 8'hC0, 4'b0100);
    directed("ror",      10, 8'h01, 8'h00, 8'h80, 4'b0110);
    directed("mul_lo",   7, 15,    15,    225,   4'b0100);
    directed("mul_hi",   7, 16,    16,    0,     4'b1010);
    directed("rol",      9, 8'h81, 8'h55, 8'h03, 4'b0010);
    directed("not",      11, 8'h0F, 8'h33, 8'hF0, 4'b0100);
    directed("inc_ovf",  12, 8'h7F, 8'h99, 8'h80, 4'b0101);
    directed("dec_brw",  13, 8'h00, 8'h99, 8'hFF, 4'b0110);
    directed("dec_ovf",  13, 8'h80, 8'h00, 8'h7F, 4'b0001);
    directed("cmp_eq",   14, 8'h42, 8'h42, 8'h00, 4'b1000);
    directed("pasb",     15, 8'h11, 8'h9C, 8'h9C, 4'b0100);
    idle_check("idle1");
    idle_check("idle2");

    // Random ops against the model, with occasional idle gaps.
    for (int i = 0; i < 300; i++) begin
      op = int'($urandom_range(15));
      ua = int'($urandom_range(255));
      ub = int'($urandom_range(255));
      model(op, ua, ub, er, ef);
      drive(op, ua, ub);
      chk($sformatf("rnd%0d_op%0h_valid", i, op), int'(bus.out_valid), 1);
      chk($sformatf("rnd%0d_op%0h_result", i, op), int'(bus.result), er);
      chk($sformatf("rnd%0d_op%0h_flags", i, op), flags_now(), ef);
      last_r = er;
      last_f = ef;
      if ($urandom_range(7) == 0) idle_check($sformatf("rnd%0d_idle", i));
    end

    idle_check("final_idle");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
